div_radix2: RTL and testbench
=============================

DIV_RADIX2 -- requirements
Module: div_radix2

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset; all state updates on the rising edge of clk.
REQ-002 clk  input  1  system clock.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 signed_div_i  input  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start_i in IDLE.
REQ-005 opdata1_i  input  32  dividend; sampled in IDLE.
REQ-006 opdata2_i  input  32  divisor; sampled in IDLE.
REQ-007 start_i  input  1  request; requester holds it high until ready_o is seen.
REQ-008 annul_i  input  1  abort the in-flight operation (pipeline flush).
REQ-009 result_o  output  64  {remainder[63:32] -> HI, quotient[31:0] -> LO}.
REQ-010 ready_o  output  1  one-cycle pulse; result_o valid in the same cycle.

Function
REQ-011 SHALL implement FSM states IDLE, BYZERO, ON, END.
REQ-012 IDLE: on start_i=1 and annul_i=0, SHALL latch the operands; divisor=0 -> BYZERO, else -> ON with iteration count 0.
REQ-013 Signed mode: SHALL latch the absolute values of both operands and record sign_q = sign(op1)^sign(op2) and sign_r = sign(op1).
REQ-014 Unsigned mode: SHALL use the operands unmodified, with sign_q = sign_r = 0.
REQ-015 ON: SHALL perform one restoring shift-subtract step per cycle on a 65-bit working register.
REQ-016 ON: SHALL run exactly 32 iterations, then go to END.
REQ-017 END: SHALL negate the quotient if sign_q and the remainder if sign_r (two's complement, 32-bit wrap).
REQ-018 END: SHALL drive result_o and ready_o=1 for exactly one cycle, then go to IDLE.
REQ-019 Latency: start sampled in cycle 0; ready_o SHALL assert in cycle 33.
REQ-020 BYZERO: SHALL go to END next cycle with result 64'h0; ready_o SHALL assert in cycle 2.
REQ-021 Signed 0x80000000 / 0xFFFFFFFF SHALL yield quotient 0x80000000, remainder 0 (wrap, no trap).
REQ-022 In BYZERO or ON, annul_i=1 or start_i=0 SHALL abort to IDLE next cycle; no ready_o pulse for the aborted operation.
REQ-023 annul_i=1 in the same cycle as start_i in IDLE SHALL suppress the start.
REQ-024 annul_i in END SHALL NOT suppress that cycle's ready_o pulse.
REQ-025 start_i still high in the cycle after END SHALL begin a new operation; the requester deasserts it to avoid this.
REQ-026 ready_o SHALL be 0 in every state except END.

Reset
REQ-027 rst=1 SHALL force IDLE, iteration count 0, working register 0, result_o=64'h0, ready_o=0 on the next edge, including mid-operation.
REQ-028 After reset, the first start_i SHALL behave exactly as in REQ-012.

Configuration
REQ-029 Macro DIV_RESULT_HOLD_EN defined: result_o SHALL hold the last END result until the next operation's END or reset, including through aborts.
REQ-030 Macro DIV_RESULT_HOLD_EN undefined: result_o SHALL be 64'h0 in every cycle except END.
REQ-031 ready_o timing and quotient/remainder values SHALL be identical in both configurations.

Verification
REQ-032 Unsigned 100 / 7, start held -> ready_o in cycle 33, result_o = {32'd2, 32'd14}, ready_o low in cycle 34.
REQ-033 Signed -7 / 2 (0xFFFFFFF9, 0x2) -> result_o = {32'hFFFFFFFF, 32'hFFFFFFFD}.
REQ-034 Signed 0x80000000 / 0xFFFFFFFF -> result_o = {32'h0, 32'h80000000}.
REQ-035 Divisor 0, dividend 0x1234 -> ready_o in cycle 2, result_o = 64'h0.
REQ-036 annul_i pulsed in cycle 10 of 100 / 7 -> no ready_o through cycle 40; next start of 9 / 3 -> ready_o in its cycle 33 with {0, 3}.
REQ-037 rst in cycle 15 of an operation -> ready_o=0 and result_o=0 next cycle; a following start completes normally.
REQ-038 Each scenario SHALL run with DIV_RESULT_HOLD_EN defined and undefined; check result_o hold versus clear after END.

Source files
------------

// File: rtl/div_radix2_if.sv
// -----------------------------------------------------------------------------
// div_radix2_if -- request/response bundle for the radix-2 divider.
//
// Members:
//   signed_div_i  1   1 = signed divide, 0 = unsigned divide
//   opdata1_i     32  dividend
//   opdata2_i     32  divisor
//   start_i       1   request, held high by the requester until ready_o
//   annul_i       1   abort of the in-flight operation (pipeline flush)
//   result_o      64  {remainder, quotient}
//   ready_o       1   one-cycle completion pulse, result_o valid alongside
//
// Modports: master = requester side, slave = divider side.
// -----------------------------------------------------------------------------
interface div_if;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );
endinterface

// File: rtl/div_radix2.sv
// -----------------------------------------------------------------------------
// div_radix2 -- 32-bit signed/unsigned restoring divider, one quotient bit per
// clock.
//
// Ports:
//   clk  system clock (all state changes on the rising edge)
//   rst  synchronous active-high reset
//   bus  div_if.slave: operands, start/annul request, {rem, quo} result and
//        a one-cycle ready pulse
//
// Timing: start sampled in cycle 0, ready_o in cycle 33 (cycle 2 for a zero
// divisor, which returns 64'h0). Dropping start_i or raising annul_i while
// busy abandons the operation without a ready pulse.
//
// Configuration macro DIV_RESULT_HOLD_EN:
//   defined   -> result_o keeps the last completed result until the next
//                completion or reset (aborts leave it untouched)
//   undefined -> result_o is 64'h0 except in the ready cycle
// -----------------------------------------------------------------------------
module div_radix2 (
  input  logic clk,
  input  logic rst,
  div_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BYZERO = 2'd1,
    S_ON     = 2'd2,
    S_END    = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [64:0] work_q, work_d;      // [64:32] partial remainder, [31:0] quotient
  logic [31:0] divisor_q, divisor_d;
  logic        sign_quo_q, sign_quo_d;
  logic        sign_rem_q, sign_rem_d;
  logic [63:0] result_q, result_d;
  logic        ready_q, ready_d;

  logic [64:0] step_s;
  logic [31:0] quo_fix_s;
  logic [31:0] rem_fix_s;
  logic [31:0] op1_abs_s;
  logic [31:0] op2_abs_s;

  // One restoring step: shift left, keep the trial subtraction if it did not
  // go negative. The 34-bit trial keeps the bit shifted out of [64].
  function automatic logic [64:0] div_step(input logic [64:0] w, input logic [31:0] d);
    logic [33:0] trial;
    trial = w[64:31] - {2'b00, d};
    if (!trial[33]) begin
      div_step = {trial[32:0], w[30:0], 1'b1};
    end else begin
      div_step = {w[63:0], 1'b0};
    end
  endfunction

  // Datapath helpers: operand magnitudes and sign-corrected final result.
  always_comb begin
    step_s    = div_step(work_q, divisor_q);
    op1_abs_s = (bus.signed_div_i && bus.opdata1_i[31]) ? (32'd0 - bus.opdata1_i) : bus.opdata1_i;
    op2_abs_s = (bus.signed_div_i && bus.opdata2_i[31]) ? (32'd0 - bus.opdata2_i) : bus.opdata2_i;
    quo_fix_s = sign_quo_q ? (32'd0 - step_s[31:0])  : step_s[31:0];
    rem_fix_s = sign_rem_q ? (32'd0 - step_s[63:32]) : step_s[63:32];
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    work_d     = work_q;
    divisor_d  = divisor_q;
    sign_quo_d = sign_quo_q;
    sign_rem_d = sign_rem_q;
    ready_d    = 1'b0;
`ifdef DIV_RESULT_HOLD_EN
    result_d   = result_q;
`else
    result_d   = 64'h0;
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.start_i && !bus.annul_i) begin
          divisor_d  = op2_abs_s;
          sign_quo_d = bus.signed_div_i & (bus.opdata1_i[31] ^ bus.opdata2_i[31]);
          sign_rem_d = bus.signed_div_i & bus.opdata1_i[31];
          cnt_d      = 6'd0;
          work_d     = {33'd0, op1_abs_s};
          if (bus.opdata2_i == 32'd0) begin
            state_d = S_BYZERO;
          end else begin
            state_d = S_ON;
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_BYZERO: begin
        if (bus.annul_i || !bus.start_i) begin
          state_d = S_IDLE;
        end else begin
          state_d  = S_END;
          ready_d  = 1'b1;
          result_d = 64'h0;
        end
      end

      S_ON: begin
        if (bus.annul_i || !bus.start_i) begin
          state_d = S_IDLE;
        end else begin
          work_d = step_s;
          if (cnt_q == 6'd31) begin
            // Last step: result and ready are registered on the way into END.
            state_d  = S_END;
            ready_d  = 1'b1;
            result_d = {rem_fix_s, quo_fix_s};
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
      end

      S_END: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 6'd0;
      work_q     <= 65'd0;
      divisor_q  <= 32'd0;
      sign_quo_q <= 1'b0;
      sign_rem_q <= 1'b0;
      result_q   <= 64'h0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      work_q     <= work_d;
      divisor_q  <= divisor_d;
      sign_quo_q <= sign_quo_d;
      sign_rem_q <= sign_rem_d;
      result_q   <= result_d;
      ready_q    <= ready_d;
    end
  end

  assign bus.result_o = result_q;
  assign bus.ready_o  = ready_q;

endmodule

// File: tb/tb_div_radix2.sv
// -----------------------------------------------------------------------------
// tb_div_radix2 -- self-checking bench for div_radix2. Expected results come
// from a 64-bit integer division model; result_o behaviour outside the ready
// cycle follows DIV_RESULT_HOLD_EN as compiled.
// -----------------------------------------------------------------------------
module tb_div_radix2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  div_if bus ();

  div_radix2 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_pass  = 0;
  int n_total = 0;
  logic [63:0] last_res = 64'h0;

  // Reference: plain integer division, remainder takes the dividend's sign.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'h0;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  function automatic logic [63:0] idle_res();
`ifdef DIV_RESULT_HOLD_EN
    return last_res;
`else
    return 64'h0;
`endif
  endfunction

  // Hold start high until ready_o (bounded); lat = edges to ready, -1 on timeout.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                        output int lat, output logic [63:0] res);
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.signed_div_i = sgn;
    bus.annul_i      = 1'b0;
    bus.start_i      = 1'b1;
    lat = -1;
    res = 64'h0;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk); #1;
      if (bus.ready_o) begin
        lat = c;
        res = bus.result_o;
        break;
      end
    end
    bus.start_i = 1'b0;
  endtask

  task automatic test_reset();
    bus.start_i = 1'b0; bus.annul_i = 1'b0; bus.signed_div_i = 1'b0;
    bus.opdata1_i = 32'd0; bus.opdata2_i = 32'd0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    last_res = 64'h0;
    n_total++;
    if (bus.ready_o !== 1'b0) $display("FAIL reset_ready got=%b exp=0", bus.ready_o); else n_pass++;
    n_total++;
    if (bus.result_o !== 64'h0) $display("FAIL reset_result got=%h exp=0", bus.result_o); else n_pass++;
  endtask

  logic [31:0] d_a  [4] = '{32'd100, 32'hFFFFFFF9, 32'h80000000, 32'h1234};
  logic [31:0] d_b  [4] = '{32'd7,   32'h2,        32'hFFFFFFFF, 32'h0};
  logic        d_s  [4] = '{1'b0,    1'b1,         1'b1,         1'b0};
  logic [63:0] d_r  [4] = '{{32'd2, 32'd14}, {32'hFFFFFFFF, 32'hFFFFFFFD},
                            {32'h0, 32'h80000000}, 64'h0};
  int          d_l  [4] = '{33, 33, 33, 2};

  task automatic test_directed();
    int lat;
    logic [63:0] res;
    for (int i = 0; i < 4; i++) begin
      run_op(d_a[i], d_b[i], d_s[i], lat, res);
      n_total++;
      if (lat != d_l[i]) $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, d_l[i]); else n_pass++;
      n_total++;
      if (res !== d_r[i]) $display("FAIL dir%0d_result got=%h exp=%h", i, res, d_r[i]); else n_pass++;
      last_res = d_r[i];
      @(posedge clk); #1;
      n_total++;
      if (bus.ready_o !== 1'b0) $display("FAIL dir%0d_ready_after got=%b exp=0", i, bus.ready_o); else n_pass++;
      n_total++;
      if (bus.result_o !== idle_res()) $display("FAIL dir%0d_result_after got=%h exp=%h", i, bus.result_o, idle_res()); else n_pass++;
    end
  endtask

  task automatic test_random();
    int lat, exp_lat;
    logic [63:0] res, exp;
    logic [31:0] a, b;
    logic sgn;
    for (int i = 0; i < 24; i++) begin
      sgn = 1'($urandom_range(0, 1));
      a   = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = $urandom;
        default: b = ($urandom_range(0, 1) != 0) ? 32'hFFFFFFFF : 32'h80000000;
      endcase
      if (i == 0) a = 32'h80000000;
      exp     = ref_div(a, b, sgn);
      exp_lat = (b == 32'd0) ? 2 : 33;
      run_op(a, b, sgn, lat, res);
      n_total++;
      if (lat != exp_lat) $display("FAIL rnd%0d_latency got=%0d exp=%0d", i, lat, exp_lat); else n_pass++;
      n_total++;
      if (res !== exp) $display("FAIL rnd%0d_result a=%h b=%h s=%b got=%h exp=%h", i, a, b, sgn, res, exp); else n_pass++;
      last_res = exp;
      @(posedge clk); #1;
      n_total++;
      if (bus.result_o !== idle_res()) $display("FAIL rnd%0d_result_after got=%h exp=%h", i, bus.result_o, idle_res()); else n_pass++;
    end
  endtask

  // Watch cycles after an abort: no ready pulse, result_o per configuration.
  task automatic watch_quiet(input string name, input int cycles);
    int pulses = 0;
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk); #1;
      if (bus.ready_o) pulses++;
    end
    n_total++;
    if (pulses != 0) $display("FAIL %s_no_ready got=%0d pulses exp=0", name, pulses); else n_pass++;
    n_total++;
    if (bus.result_o !== idle_res()) $display("FAIL %s_result got=%h exp=%h", name, bus.result_o, idle_res()); else n_pass++;
  endtask

  task automatic test_annul();
    int lat;
    logic [63:0] res;
    bus.opdata1_i = 32'd100; bus.opdata2_i = 32'd7; bus.signed_div_i = 1'b0;
    bus.annul_i = 1'b0; bus.start_i = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
    bus.annul_i = 1'b1; bus.start_i = 1'b0;
    @(posedge clk); #1;
    bus.annul_i = 1'b0;
    n_total++;
    if (bus.ready_o !== 1'b0) $display("FAIL annul_ready_c11 got=%b exp=0", bus.ready_o); else n_pass++;
    watch_quiet("annul", 29);
    run_op(32'd9, 32'd3, 1'b0, lat, res);
    n_total++;
    if (lat != 33) $display("FAIL annul_next_latency got=%0d exp=33", lat); else n_pass++;
    n_total++;
    if (res !== {32'd0, 32'd3}) $display("FAIL annul_next_result got=%h exp=%h", res, {32'd0, 32'd3}); else n_pass++;
    last_res = {32'd0, 32'd3};
    @(posedge clk); #1;
  endtask

  task automatic test_start_drop();
    // Drop start mid-iteration, then drop it while in BYZERO.
    bus.opdata1_i = 32'd500; bus.opdata2_i = 32'd3; bus.signed_div_i = 1'b0;
    bus.annul_i = 1'b0; bus.start_i = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    bus.start_i = 1'b0;
    watch_quiet("drop_on", 40);
    bus.opdata2_i = 32'd0; bus.start_i = 1'b1;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    watch_quiet("drop_byzero", 10);
    // annul together with start in IDLE suppresses the request.
    bus.opdata2_i = 32'd5; bus.start_i = 1'b1; bus.annul_i = 1'b1;
    @(posedge clk); #1;
    bus.start_i = 1'b0; bus.annul_i = 1'b0;
    watch_quiet("annul_idle", 40);
  endtask

  task automatic test_annul_in_end();
    logic [63:0] exp;
    int early = 0;
    exp = ref_div(32'd1000, 32'd10, 1'b0);
    bus.opdata1_i = 32'd1000; bus.opdata2_i = 32'd10; bus.signed_div_i = 1'b0;
    bus.annul_i = 1'b0; bus.start_i = 1'b1;
    repeat (32) begin
      @(posedge clk); #1;
      if (bus.ready_o) early++;
    end
    n_total++;
    if (early != 0) $display("FAIL end_annul_early got=%0d pulses exp=0", early); else n_pass++;
    @(posedge clk); #1;
    bus.annul_i = 1'b1;
    #1;
    n_total++;
    if (bus.ready_o !== 1'b1) $display("FAIL end_annul_ready got=%b exp=1", bus.ready_o); else n_pass++;
    n_total++;
    if (bus.result_o !== exp) $display("FAIL end_annul_result got=%h exp=%h", bus.result_o, exp); else n_pass++;
    last_res = exp;
    bus.start_i = 1'b0;
    @(posedge clk); #1;
    bus.annul_i = 1'b0;
    n_total++;
    if (bus.ready_o !== 1'b0) $display("FAIL end_annul_after got=%b exp=0", bus.ready_o); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int lat1, lat2;
    logic [63:0] r1, r2;
    run_op(32'd50, 32'd5, 1'b0, lat1, r1);
    // run_op dropped start; put it back within the END cycle with new operands.
    bus.opdata1_i = 32'd81; bus.opdata2_i = 32'd9; bus.start_i = 1'b1;
    lat2 = -1; r2 = 64'h0;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk); #1;
      if (bus.ready_o) begin lat2 = c; r2 = bus.result_o; break; end
    end
    bus.start_i = 1'b0;
    n_total++;
    if (lat1 != 33) $display("FAIL b2b_lat1 got=%0d exp=33", lat1); else n_pass++;
    n_total++;
    if (r1 !== {32'd0, 32'd10}) $display("FAIL b2b_res1 got=%h exp=%h", r1, {32'd0, 32'd10}); else n_pass++;
    n_total++;
    if (lat2 != 34) $display("FAIL b2b_lat2 got=%0d exp=34", lat2); else n_pass++;
    n_total++;
    if (r2 !== {32'd0, 32'd9}) $display("FAIL b2b_res2 got=%h exp=%h", r2, {32'd0, 32'd9}); else n_pass++;
    last_res = {32'd0, 32'd9};
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int lat;
    logic [63:0] res;
    bus.opdata1_i = 32'd100; bus.opdata2_i = 32'd7; bus.signed_div_i = 1'b0;
    bus.annul_i = 1'b0; bus.start_i = 1'b1;
    repeat (15) begin @(posedge clk); #1; end
    rst = 1'b1; bus.start_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    last_res = 64'h0;
    n_total++;
    if (bus.ready_o !== 1'b0) $display("FAIL rstmid_ready got=%b exp=0", bus.ready_o); else n_pass++;
    n_total++;
    if (bus.result_o !== 64'h0) $display("FAIL rstmid_result got=%h exp=0", bus.result_o); else n_pass++;
    watch_quiet("rstmid_quiet", 40);
    run_op(32'hFFFFFF9C, 32'd7, 1'b1, lat, res);
    n_total++;
    if (lat != 33) $display("FAIL rstmid_next_latency got=%0d exp=33", lat); else n_pass++;
    n_total++;
    if (res !== ref_div(32'hFFFFFF9C, 32'd7, 1'b1))
      $display("FAIL rstmid_next_result got=%h exp=%h", res, ref_div(32'hFFFFFF9C, 32'd7, 1'b1));
    else n_pass++;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_annul();
    test_start_drop();
    test_annul_in_end();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
